// File: rtl/uart_word_loader.sv
// uart_word_loader: assembles UART bytes into memory words, writes them to
// sequential addresses, and ends the load on a run of terminator words.
module uart_word_loader #(
  parameter int unsigned               WORD_BYTES = 4,
  parameter int unsigned               DEPTH      = 256,
  parameter bit                        MSB_FIRST  = 1'b0,
  parameter logic [8*WORD_BYTES-1:0]   TERM_WORD  = '1,
  parameter int unsigned               TERM_COUNT = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         load_en,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_break,
  output logic                         mem_we,
  output logic [$clog2(DEPTH)-1:0]     mem_addr,
  output logic [8*WORD_BYTES-1:0]      mem_wdata,
  output logic                         busy,
  output logic                         write_done,
  output logic                         load_err,
  output logic [$clog2(DEPTH):0]       word_count,
  output logic [7:0]                   checksum
);

  localparam int unsigned W      = 8 * WORD_BYTES;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned RUN_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [IDX_W-1:0]    r_byte_idx, w_byte_idx_nxt;
  logic [W-1:0]        r_word,     w_word_nxt;
  logic [RUN_W-1:0]    r_run,      w_run_nxt;
  logic [7:0]          r_csum,     w_csum_nxt;
  logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
  logic                r_we,       w_we_nxt;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
  logic [W-1:0]        r_wdata,    w_wdata_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_err,      w_err_nxt;

  logic [IDX_W-1:0]    w_lane;
  logic [W-1:0]        w_word_asm;
  logic                w_last;
  logic                w_full;
  logic                w_is_term;
  logic [RUN_W-1:0]    w_run_inc;

  // Byte lane for the incoming byte and word-boundary / capacity flags
  always_comb begin
    w_lane    = MSB_FIRST ? (IDX_W'(WORD_BYTES - 1) - r_byte_idx) : r_byte_idx;
    w_last    = (r_byte_idx == IDX_W'(WORD_BYTES - 1));
    w_full    = (r_cnt == CNT_W'(DEPTH));
    w_run_inc = r_run + RUN_W'(1);
  end

  // Merge the incoming byte into the partially assembled word
  always_comb begin
    w_word_asm = r_word;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      if (IDX_W'(k) == w_lane) begin
        w_word_asm[8*k +: 8] = rx_data;
      end
    end
    w_is_term = (w_word_asm == TERM_WORD);
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_word_nxt     = r_word;
    w_run_nxt      = r_run;
    w_csum_nxt     = r_csum;
    w_cnt_nxt      = r_cnt;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_err_nxt      = r_err;

    case (r_state)
      S_IDLE: begin
        if (load_en) begin
          w_state_nxt    = S_COLLECT;
          w_byte_idx_nxt = '0;
          w_run_nxt      = '0;
          w_csum_nxt     = '0;
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b0;
        end
      end
      S_COLLECT: begin
        if (!load_en) begin
          // Abandon the session; partial word dropped, counters kept
          w_state_nxt    = S_IDLE;
          w_byte_idx_nxt = '0;
        end else if (rx_break) begin
          // Restart in place; a byte arriving with the break is dropped
          w_byte_idx_nxt = '0;
          w_run_nxt      = '0;
          w_csum_nxt     = '0;
          w_cnt_nxt      = '0;
        end else if (rx_valid) begin
          w_csum_nxt = r_csum + rx_data;
          w_word_nxt = w_word_asm;
          if (w_last) begin
            w_byte_idx_nxt = '0;
            if (w_full) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_ERR;
            end else begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_cnt[ADDR_W-1:0];
              w_wdata_nxt = w_word_asm;
              w_cnt_nxt   = r_cnt + CNT_W'(1);
              w_run_nxt   = w_is_term ? w_run_inc : '0;
              if (w_is_term && (w_run_inc == RUN_W'(TERM_COUNT))) begin
                w_state_nxt = S_DONE;
              end
            end
          end else begin
            w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!load_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_COLLECT);
    // Completion flag trails the final write by one cycle
    w_done_nxt = (r_state == S_DONE) && (w_state_nxt == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_run      <= '0;
      r_csum     <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word     <= w_word_nxt;
      r_run      <= w_run_nxt;
      r_csum     <= w_csum_nxt;
      r_cnt      <= w_cnt_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = r_busy;
  assign write_done = r_done;
  assign load_err   = r_err;
  assign word_count = r_cnt;
  assign checksum   = r_csum;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: four configurations share one stimulus.
module tb_uart_word_loader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       load_en;
  logic       rx_valid;
  logic       rx_break;
  logic [7:0] rx_data;

  // defaults (little-endian, 4 bytes, depth 256)
  logic le_we, le_busy, le_done, le_err;
  logic [7:0] le_addr, le_csum;
  logic [31:0] le_wdata;
  logic [8:0] le_cnt;
  // MSB_FIRST=1
  logic be_we, be_busy, be_done, be_err;
  logic [7:0] be_addr, be_csum;
  logic [31:0] be_wdata;
  logic [8:0] be_cnt;
  // WORD_BYTES=2
  logic w2_we, w2_busy, w2_done, w2_err;
  logic [7:0] w2_addr, w2_csum;
  logic [15:0] w2_wdata;
  logic [8:0] w2_cnt;
  // DEPTH=4
  logic d4_we, d4_busy, d4_done, d4_err;
  logic [1:0] d4_addr;
  logic [7:0] d4_csum;
  logic [31:0] d4_wdata;
  logic [2:0] d4_cnt;

  uart_word_loader u_le (
    .clk(clk), .resetn(resetn), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_break(rx_break), .mem_we(le_we), .mem_addr(le_addr),
    .mem_wdata(le_wdata), .busy(le_busy), .write_done(le_done), .load_err(le_err),
    .word_count(le_cnt), .checksum(le_csum));

  uart_word_loader #(.MSB_FIRST(1'b1)) u_be (
    .clk(clk), .resetn(resetn), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_break(rx_break), .mem_we(be_we), .mem_addr(be_addr),
    .mem_wdata(be_wdata), .busy(be_busy), .write_done(be_done), .load_err(be_err),
    .word_count(be_cnt), .checksum(be_csum));

  uart_word_loader #(.WORD_BYTES(2)) u_w2 (
    .clk(clk), .resetn(resetn), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_break(rx_break), .mem_we(w2_we), .mem_addr(w2_addr),
    .mem_wdata(w2_wdata), .busy(w2_busy), .write_done(w2_done), .load_err(w2_err),
    .word_count(w2_cnt), .checksum(w2_csum));

  uart_word_loader #(.DEPTH(4)) u_d4 (
    .clk(clk), .resetn(resetn), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_break(rx_break), .mem_we(d4_we), .mem_addr(d4_addr),
    .mem_wdata(d4_wdata), .busy(d4_busy), .write_done(d4_done), .load_err(d4_err),
    .word_count(d4_cnt), .checksum(d4_csum));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Write logs per configuration
  logic [63:0] le_wa [64];
  logic [63:0] le_wd [64];
  logic [63:0] w2_wa [64];
  logic [63:0] w2_wd [64];
  logic [63:0] d4_wa [64];
  logic [63:0] d4_wd [64];
  int le_wn = 0;
  int w2_wn = 0;
  int d4_wn = 0;

  // Capture each write pulse once, just after the edge that raised it
  always @(posedge clk) begin
    #1;
    if (le_we && le_wn < 64) begin
      le_wa[le_wn] = 64'(le_addr); le_wd[le_wn] = 64'(le_wdata); le_wn = le_wn + 1;
    end
    if (w2_we && w2_wn < 64) begin
      w2_wa[w2_wn] = 64'(w2_addr); w2_wd[w2_wn] = 64'(w2_wdata); w2_wn = w2_wn + 1;
    end
    if (d4_we && d4_wn < 64) begin
      d4_wa[d4_wn] = 64'(d4_addr); d4_wd[d4_wn] = 64'(d4_wdata); d4_wn = d4_wn + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_session();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_session();
    @(negedge clk);
    load_en = 1'b0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    logic [31:0] words [5];
    resetn = 1'b0; load_en = 1'b0; rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
    tick(3);
    check("rst_le", {le_we, le_addr, le_wdata, le_busy, le_done, le_err, le_cnt, le_csum}, 64'd0);
    check("rst_be", {be_we, be_addr, be_wdata, be_busy, be_done, be_err, be_cnt, be_csum}, 64'd0);
    check("rst_w2", {w2_we, w2_addr, w2_wdata, w2_busy, w2_done, w2_err, w2_cnt, w2_csum}, 64'd0);
    check("rst_d4", {d4_we, d4_addr, d4_wdata, d4_busy, d4_done, d4_err, d4_cnt, d4_csum}, 64'd0);
    resetn = 1'b1;

    // Bytes while idle are ignored
    send_byte(8'h5A);
    tick(1);
    check("idle_busy", le_busy, 1'b0);
    check("idle_csum", le_csum, 8'h00);
    check("idle_writes", le_wn, 0);

    // Async reset mid-word discards progress without a clock edge
    start_session();
    check("arm_busy", le_busy, 1'b1);
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_rst_csum", le_csum, 8'h33);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_csum", le_csum, 8'h00);
    check("mid_rst_busy", le_busy, 1'b0);
    load_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick(1);

    // Byte order: little- and big-endian from the same four bytes
    start_session();
    b = le_wn;
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h01); send_byte(8'hFB);
    check("le_we_pulse", le_we, 1'b1);
    check("le_addr", le_addr, 8'h00);
    check("le_data", le_wdata, 32'hFB010113);
    check("le_cnt", le_cnt, 9'd1);
    check("le_csum", le_csum, 8'h10);
    check("be_data", be_wdata, 32'h130101FB);
    check("be_addr_cnt", {be_addr, be_cnt, be_csum}, {8'h00, 9'd1, 8'h10});
    tick(1);
    check("le_we_drop", le_we, 1'b0);
    check("le_nwrites", le_wn - b, 1);
    end_session();

    // Two-byte words
    start_session();
    b = w2_wn;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    tick(1);
    check("w2_nwrites", w2_wn - b, 2);
    check("w2_w0", {w2_wa[b], w2_wd[b]}, {64'd0, 64'h0000_BBAA});
    check("w2_w1", {w2_wa[b+1], w2_wd[b+1]}, {64'd1, 64'h0000_DDCC});
    check("w2_cnt", w2_cnt, 9'd2);
    end_session();

    // Terminator run of two ends the load; a lone one does not
    words[0] = 32'h00000000; words[1] = 32'hFFFFFFFF; words[2] = 32'h00000013;
    words[3] = 32'hFFFFFFFF; words[4] = 32'hFFFFFFFF;
    start_session();
    b = le_wn;
    for (int i = 0; i < 4; i++) send_word(words[i]);
    check("term_busy4", le_busy, 1'b1);
    check("term_done4", le_done, 1'b0);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    check("term_we5", le_we, 1'b1);
    check("term_done_same", le_done, 1'b0);
    check("term_busy_fall", le_busy, 1'b0);
    tick(1);
    check("term_done_next", le_done, 1'b1);
    check("term_nwrites", le_wn - b, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("term_w%0d", i), {le_wa[b+i], le_wd[b+i]}, {64'(i), 64'(words[i])});
    send_word(32'h11223344);
    tick(2);
    check("term_after", le_wn - b, 5);
    check("term_done_hold", le_done, 1'b1);
    check("term_cnt", le_cnt, 9'd5);
    end_session();
    check("term_done_clr", le_done, 1'b0);

    // Break mid-word restarts the session
    start_session();
    b = le_wn;
    send_byte(8'h55); send_byte(8'h66);
    @(negedge clk); rx_break = 1'b1;
    @(negedge clk); rx_break = 1'b0;
    send_byte(8'h93); send_byte(8'h07); send_byte(8'h10); send_byte(8'h00);
    tick(1);
    check("brk_nwrites", le_wn - b, 1);
    check("brk_w0", {le_wa[b], le_wd[b]}, {64'd0, 64'h0000_0000_0010_0793});
    check("brk_cnt", le_cnt, 9'd1);
    check("brk_csum", le_csum, 8'hAA);
    end_session();

    // Overflow at DEPTH=4
    start_session();
    b = d4_wn;
    for (int i = 1; i <= 5; i++) send_word(32'(i));
    check("ovf_no_we", d4_we, 1'b0);
    check("ovf_err", d4_err, 1'b1);
    check("ovf_busy", d4_busy, 1'b0);
    check("ovf_cnt", d4_cnt, 3'd4);
    tick(1);
    check("ovf_nwrites", d4_wn - b, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_w%0d", i), {d4_wa[b+i], d4_wd[b+i]}, {64'(i), 64'(i + 1)});
    end_session();
    check("ovf_sticky", d4_err, 1'b1);
    start_session();
    check("ovf_err_clr", d4_err, 1'b0);
    send_word(32'hCAFE0001);
    check("ovf_restart_we", d4_we, 1'b1);
    check("ovf_restart_addr", d4_addr, 2'd0);
    check("ovf_restart_data", d4_wdata, 32'hCAFE0001);
    end_session();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
